if_id_queue: RTL and testbench

Parametrised IF/ID pipeline stage that replaces the single-entry IF/ID latch with a DEPTH-entry in-order instruction queue. Fetch pushes {pc, inst} pairs through a valid/ready handshake, and decode pops them under a downstream stall. A branch/jump resolved in EX flushes every queued entry. Sits between the fetch unit and the ID stage of the RISC-V core.

---
 rtl/if_id_queue_pkg.sv | 18 +
 rtl/if_id_queue_mem.sv | 25 ++
 rtl/if_id_queue.sv | 96 +++++++++
 tb/tb_if_id_queue.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared widths, reset polarity and queue op encoding for the IF/ID queue
package if_id_queue_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic RST_ENABLE = 1'b1;
  localparam logic TRUE_V     = 1'b1;
  localparam logic FALSE_V    = 1'b0;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } queue_op_e;

endpackage

// File: rtl/if_id_queue_mem.sv
// rtl/if_id_queue_mem.sv - DEPTH x W register array, one write port, one async read port, no reset
module if_id_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - DEPTH-entry in-order IF/ID instruction queue with EX-driven flush
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int XLEN  = INST_ADDR_BUS,
  parameter int ILEN  = INST_BUS,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_pc,
  input  logic [ILEN-1:0]  if_inst,
  output logic             if_ready,
  input  logic             ex_be_i,
  input  logic             stall_i,
  output logic             id_valid,
  output logic [XLEN-1:0]  id_pc,
  output logic [ILEN-1:0]  id_inst,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W:0]        cnt;
  logic                  push;
  logic                  pop;
  queue_op_e             op;
  logic [XLEN+ILEN-1:0]  head;

  // Ready and valid come only from registered count; no pass-through when full.
  assign if_ready = (cnt != FULL_CNT);
  assign id_valid = (cnt != '0);
  assign count    = cnt;

  assign push = if_valid && if_ready && !ex_be_i;
  assign pop  = id_valid && !stall_i && !ex_be_i;
  assign op   = queue_op_e'({push, pop});

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (ex_be_i == TRUE_V) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          cnt    <= cnt + 1'b1;
        end
        OP_POP: begin
          rd_ptr <= rd_ptr + PTR_ONE;
          cnt    <= cnt - 1'b1;
        end
        OP_BOTH: begin
          wr_ptr <= wr_ptr + PTR_ONE;
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        default: ;
      endcase
    end
  end

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .W     (XLEN + ILEN),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({if_pc, if_inst}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Storage is never cleared, so an empty queue must present an all-zero bubble.
  assign id_pc   = id_valid ? head[XLEN+ILEN-1:ILEN] : '0;
  assign id_inst = id_valid ? head[ILEN-1:0]         : '0;

  always_ff @(posedge clk) begin
    if (rst != RST_ENABLE) begin
      assert (cnt <= FULL_CNT)
        else $error("if_id_queue count %0d exceeds depth", cnt);
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed self-checking bench for if_id_queue
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        ex_be_i;
  logic        stall_i;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  if_id_queue dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .ex_be_i  (ex_be_i),
    .stall_i  (stall_i),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pc);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = pc ^ 32'hA5A5_0000;
    step();
    if_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_inst = '0; ex_be_i = 1'b0; stall_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_id_valid", id_valid, 0);
    check("rst_id_pc",    id_pc,    0);
    check("rst_id_inst",  id_inst,  0);
    check("rst_if_ready", if_ready, 1);
    check("rst_count",    count,    0);

    // single push
    if_valid = 1'b1; if_pc = 32'h4; if_inst = 32'h0010_0093;
    step();
    if_valid = 1'b0;
    check("single_valid", id_valid, 1);
    check("single_pc",    id_pc,    32'h4);
    check("single_inst",  id_inst,  32'h0010_0093);
    check("single_count", count,    1);
    step();
    check("single_drained", count,   0);
    check("single_bubble",  id_pc,   0);
    check("single_bubble_inst", id_inst, 0);

    // fill under stall, crossing pointer wrap (pointers start at 1 here)
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) push_one(32'(4 * i));
    check("fill_count",    count,    4);
    check("fill_ready",    if_ready, 0);
    check("fill_head",     id_pc,    32'h0);
    push_one(32'h10);
    check("fill_fifth_count", count, 4);
    check("fill_fifth_head",  id_pc, 32'h0);
    stall_i = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc",   id_pc,   32'(4 * i));
      check("drain_inst", id_inst, 32'(4 * i) ^ 32'hA5A5_0000);
      step();
    end
    check("drain_empty", id_valid, 0);
    check("drain_no_extra_pc", id_pc, 0);

    // flush with simultaneous push
    stall_i = 1'b1;
    push_one(32'h20);
    push_one(32'h24);
    push_one(32'h28);
    check("pre_flush_count", count, 3);
    ex_be_i = 1'b1; if_valid = 1'b1; if_pc = 32'h100; if_inst = 32'h1;
    step();
    ex_be_i = 1'b0; if_valid = 1'b0; stall_i = 1'b0;
    check("flush_count", count,    0);
    check("flush_valid", id_valid, 0);
    check("flush_pc",    id_pc,    0);
    step();
    check("flush_push_dropped", id_valid, 0);

    // flush beats stall
    stall_i = 1'b1;
    push_one(32'h40);
    push_one(32'h44);
    check("stall_flush_pre", count, 2);
    ex_be_i = 1'b1;
    step();
    ex_be_i = 1'b0;
    check("stall_flush_count", count,    0);
    check("stall_flush_valid", id_valid, 0);
    stall_i = 1'b0;

    // streaming: one per cycle
    if_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if_pc   = 32'h200 + 32'(4 * k);
      if_inst = if_pc ^ 32'h0000_0013;
      step();
      check("stream_pc",    id_pc,   32'h200 + 32'(4 * k));
      check("stream_inst",  id_inst, (32'h200 + 32'(4 * k)) ^ 32'h0000_0013);
      check("stream_count", count,   1);
    end
    if_valid = 1'b0;
    step();
    check("stream_end_count", count, 0);

    // reset overrides a push
    if_valid = 1'b1; if_pc = 32'h300; rst = 1'b1;
    step();
    rst = 1'b0; if_valid = 1'b0;
    check("rst_over_push_count", count,    0);
    check("rst_over_push_valid", id_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
